// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-ported data memory between CPU (A) and debug/DMA (B).
// Optional bus lock for atomic read-modify-write: define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              a_lock,
`endif
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              b_lock,
`endif
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;   // 1: B holds the most recent grant
  logic              lock_q, lock_d;       // current owner was granted with lock set
  logic              a_lock_c, b_lock_c;
  logic              hold_a, hold_b;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

`ifdef DMEM_ARB_LOCK_EN
  assign a_lock_c = a_lock;
  assign b_lock_c = b_lock;
`else
  assign a_lock_c = 1'b0;
  assign b_lock_c = 1'b0;
`endif

  // A locked owner that keeps requesting keeps the memory; the other port waits.
  assign hold_a = lock_q && (state_q == OWN_A) && a_req;
  assign hold_b = lock_q && (state_q == OWN_B) && b_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      lock_q   <= lock_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = IDLE;
    last_b_d = last_b_q;
    lock_d   = 1'b0;
    if (a_gnt) begin
      state_d  = OWN_A;
      last_b_d = 1'b0;
      lock_d   = a_lock_c;
    end else if (b_gnt) begin
      state_d  = OWN_B;
      last_b_d = 1'b1;
      lock_d   = b_lock_c;
    end
  end

  // Output logic: grants and memory drive
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (hold_a) begin
      a_gnt = 1'b1;
    end else if (hold_b) begin
      b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      if (FIXED_PRIO || last_b_q) a_gnt = 1'b1;
      else                        b_gnt = 1'b1;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_write = a_we;
      mem_read  = ~a_we;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_write = b_we;
      mem_read  = ~b_we;
    end
  end

  // Read return: capture combinational memory data at the end of a read grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_gnt && !a_we;
      b_rvalid_q <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata_q <= mem_rdata;
      if (b_gnt && !b_we) b_rdata_q <= mem_rdata;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance (m_) and fixed-priority instance (f_)
// share stimulus; each has its own behavioural memory.
module tb_dmem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          a_lock, b_lock;
`endif

  logic          m_a_gnt, m_a_rvalid, m_b_gnt, m_b_rvalid, m_mem_write, m_mem_read;
  logic [DW-1:0] m_a_rdata, m_b_rdata, m_mem_wdata, m_mem_rdata;
  logic [AW-1:0] m_mem_addr;
  logic          f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid, f_mem_write, f_mem_read;
  logic [DW-1:0] f_a_rdata, f_b_rdata, f_mem_wdata, f_mem_rdata;
  logic [AW-1:0] f_mem_addr;

  logic [DW-1:0] mem_m [256];
  logic [DW-1:0] mem_f [256];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .a_lock(a_lock),
`endif
    .a_gnt(m_a_gnt), .a_rvalid(m_a_rvalid), .a_rdata(m_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .b_lock(b_lock),
`endif
    .b_gnt(m_b_gnt), .b_rvalid(m_b_rvalid), .b_rdata(m_b_rdata),
    .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata), .mem_write(m_mem_write),
    .mem_read(m_mem_read), .mem_rdata(m_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .a_lock(a_lock),
`endif
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .b_lock(b_lock),
`endif
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write),
    .mem_read(f_mem_read), .mem_rdata(f_mem_rdata)
  );

  // Behavioural single-ported memories: combinational read, write on posedge
  assign m_mem_rdata = mem_m[m_mem_addr];
  assign f_mem_rdata = mem_f[f_mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = '0;
      mem_f[i] = '0;
    end
    mem_m[8'h30] = 16'hA0A0; mem_f[8'h30] = 16'hA0A0;
    mem_m[8'h31] = 16'h0B0B; mem_f[8'h31] = 16'h0B0B;
    mem_m[8'h20] = 16'h2020; mem_f[8'h20] = 16'h2020;
    forever begin
      @(posedge clk);
      if (m_mem_write) mem_m[m_mem_addr] <= m_mem_wdata;
      if (f_mem_write) mem_f[f_mem_addr] <= f_mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int na, nb;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    a_lock = 1'b0; b_lock = 1'b0;
`endif
    #1;
    check("rst_a_rvalid", 32'(m_a_rvalid), 0);
    check("rst_b_rvalid", 32'(m_b_rvalid), 0);
    check("rst_a_rdata", 32'(m_a_rdata), 0);
    check("rst_b_rdata", 32'(m_b_rdata), 0);
    check("rst_gnts", 32'({m_a_gnt, m_b_gnt}), 0);
    check("rst_mem_ctl", 32'({m_mem_write, m_mem_read}), 0);
    check("rst_mem_addr", 32'(m_mem_addr), 0);
    tick(); tick();
    rst_n = 1'b1;

    // A reads 0x10 alone
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    #1;
    check("t1_a_gnt", 32'(m_a_gnt), 1);
    check("t1_b_gnt", 32'(m_b_gnt), 0);
    check("t1_mem_read", 32'(m_mem_read), 1);
    check("t1_mem_write", 32'(m_mem_write), 0);
    check("t1_mem_addr", 32'(m_mem_addr), 'h10);
    tick();
    a_req = 1'b0;
    check("t1_a_rvalid", 32'(m_a_rvalid), 1);
    check("t1_a_rdata", 32'(m_a_rdata), 0);
    check("t1_b_rvalid", 32'(m_b_rvalid), 0);
    #1;
    check("t1_idle_mem_addr", 32'(m_mem_addr), 0);
    tick();
    check("t1_a_rvalid_drop", 32'(m_a_rvalid), 0);

    // A writes 0x1234 @0x05, B reads it back next cycle
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 16'h1234;
    #1;
    check("t2_mem_write", 32'(m_mem_write), 1);
    check("t2_mem_read", 32'(m_mem_read), 0);
    check("t2_mem_wdata", 32'(m_mem_wdata), 'h1234);
    tick();
    check("t2_wr_no_rvalid", 32'(m_a_rvalid), 0);
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h05;
    #1;
    check("t2_b_gnt", 32'(m_b_gnt), 1);
    check("t2_mem_addr", 32'(m_mem_addr), 'h05);
    tick();
    b_req = 1'b0;
    check("t2_b_rvalid", 32'(m_b_rvalid), 1);
    check("t2_b_rdata", 32'(m_b_rdata), 'h1234);
    tick();
    check("t2_b_rvalid_drop", 32'(m_b_rvalid), 0);
    check("t2_b_rdata_hold", 32'(m_b_rdata), 'h1234);

    // Continuous conflict for 6 cycles; last grant was B so A leads
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h31;
    na = 0; nb = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t3_rr_a_gnt", 32'(m_a_gnt), (i % 2 == 0) ? 1 : 0);
      check("t3_rr_b_gnt", 32'(m_b_gnt), (i % 2 == 1) ? 1 : 0);
      check("t3_fp_gnts", 32'({f_a_gnt, f_b_gnt}), 'b10);
      tick();
      if (m_a_rvalid) na++;
      if (m_b_rvalid) nb++;
      if (i % 2 == 0) check("t3_rr_a_rdata", 32'(m_a_rdata), 'hA0A0);
      else            check("t3_rr_b_rdata", 32'(m_b_rdata), 'h0B0B);
      check("t3_fp_a_rvalid", 32'(f_a_rvalid), 1);
    end
    check("t3_rr_a_pulses", 32'(na), 3);
    check("t3_rr_b_pulses", 32'(nb), 3);
    a_req = 1'b0;
    #1;
    check("t3_fp_b_gnt_after", 32'(f_b_gnt), 1);
    check("t3_fp_a_gnt_after", 32'(f_a_gnt), 0);
    tick();
    b_req = 1'b0;
    check("t3_fp_b_rvalid", 32'(f_b_rvalid), 1);
    check("t3_fp_b_rdata", 32'(f_b_rdata), 'h0B0B);
    tick();

    // Reset asserted in the middle of a granted read
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
    tick();
    check("t4_a_rvalid_pre", 32'(m_a_rvalid), 1);
    #1;
    check("t4_a_gnt_pre_rst", 32'(m_a_gnt), 1);
    #1;
    rst_n = 1'b0;
    a_req = 1'b0;
    tick();
    check("t4_rst_a_rvalid", 32'(m_a_rvalid), 0);
    check("t4_rst_a_rdata", 32'(m_a_rdata), 0);
    check("t4_rst_b_rdata", 32'(m_b_rdata), 0);
    rst_n = 1'b1;
    tick();
    check("t4_no_reissue", 32'(m_a_rvalid), 0);
    a_req = 1'b1; a_addr = 8'h31;
    b_req = 1'b1; b_addr = 8'h30;
    #1;
    check("t4_first_conflict", 32'({m_a_gnt, m_b_gnt}), 'b10);
    tick();
    check("t4_a_rdata", 32'(m_a_rdata), 'h0B0B);
    a_req = 1'b0;
    #1;
    check("t4_b_gnt", 32'(m_b_gnt), 1);
    tick();
    b_req = 1'b0;
    check("t4_b_rvalid", 32'(m_b_rvalid), 1);
    check("t4_b_rdata", 32'(m_b_rdata), 'hA0A0);

    // A write must not disturb held read data; read-after-write sees new value
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 16'h5555;
    tick();
    check("t5_wr_rvalid", 32'(m_a_rvalid), 0);
    check("t5_wr_rdata_hold", 32'(m_a_rdata), 'h0B0B);
    a_we = 1'b0;
    tick();
    a_req = 1'b0;
    check("t5_raw_rvalid", 32'(m_a_rvalid), 1);
    check("t5_raw_rdata", 32'(m_a_rdata), 'h5555);
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Last grant was A, so B wins the conflict, then holds it with lock
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20; b_lock = 1'b1;
    #1;
    check("t6_lock_c1", 32'({m_a_gnt, m_b_gnt}), 'b01);
    tick();
    check("t6_b_rdata", 32'(m_b_rdata), 'h2020);
    b_we = 1'b1; b_wdata = 16'h2021; b_lock = 1'b0;
    #1;
    check("t6_lock_c2", 32'({m_a_gnt, m_b_gnt}), 'b01);
    check("t6_lock_wr", 32'(m_mem_write), 1);
    tick();
    b_req = 1'b0; b_we = 1'b0;
    #1;
    check("t6_lock_c3", 32'(m_a_gnt), 1);
    tick();
    a_req = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported 256x16 data memory between port A (CPU load/store stage) and port B (debug/DMA loader).
- Drives the memory's addr/write_data/mem_write/mem_read pins and returns registered read data plus a valid pulse to the winning requester.
- Sits between the CPU datapath and the data memory instance at top level.

Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, data word width
- FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = port A always wins on conflict

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A access request
- a_we  in  1  port A write enable (1 = write, 0 = read)
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A granted this cycle (combinational)
- a_rvalid  out  1  port A read data valid (registered, 1-cycle pulse)
- a_rdata  out  DATA_W  port A read data (registered)
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory write_data
- mem_write  out  1  to memory mem_write
- mem_read  out  1  to memory mem_read
- mem_rdata  in  DATA_W  from memory read_data (combinational read)

Behaviour:
- Reset (rst_n low, async): a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0; owner FSM = IDLE; last_winner = B, so A wins the first conflict. Grants are combinational and read 0 while no request is present.
- Owner FSM states: IDLE, OWN_A, OWN_B. Each posedge moves to OWN_A if a_gnt, OWN_B if b_gnt, otherwise IDLE. last_winner updates only when a grant is issued.
- Grant rules, evaluated every cycle:
  - Only a_req: a_gnt = 1.
  - Only b_req: b_gnt = 1.
  - Both, FIXED_PRIO = 1: A wins.
  - Both, FIXED_PRIO = 0: the port that is not last_winner wins.
  - a_gnt and b_gnt are never both 1.
- Memory drive:
  - The granted port's addr/wdata are muxed onto mem_addr/mem_wdata.
  - mem_write = gnt & we.
  - mem_read = gnt & ~we.
  - With no grant: mem_write = mem_read = 0, and mem_addr/mem_wdata are 0.
- Write latency: the memory write commits on the posedge ending the grant cycle.
- Read latency: mem_rdata is captured into x_rdata at the posedge ending the grant cycle. x_rvalid is 1 for exactly the following cycle, then 0 unless another read was granted. Back-to-back reads give back-to-back rvalid pulses.
- x_rdata holds its last value when rvalid = 0. A write grant does not change x_rdata.
- Requester contract: hold req/we/addr/wdata stable until the cycle gnt is seen. A dropped req without gnt is legal and leaves no side effects.
- Worst-case wait in round-robin mode: one cycle per port under continuous conflict.
- A read and a write to the same address in consecutive cycles (either order, either port) return memory-ordered data: a read after a write sees the new value.
- Reset asserted mid-read: the pending rvalid is dropped and not re-issued after reset.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs a_lock and b_lock (1 bit each).
  - When the current owner was granted with its lock = 1, the FSM stays in OWN_x. The other port is refused grants until a cycle in which the owner has req = 0 or lock = 0; that cycle reverts to normal arbitration.
  - Intended for atomic read-modify-write sequences by the debug port.
  - The lock bit of a non-owner is ignored.
- Not defined: no lock ports, and arbitration is purely per-cycle as described above.

Test Plan:
- Reset, then a_req = 1 read at addr 0x10 -> a_gnt = 1 same cycle, mem_read = 1, a_rvalid = 1 next cycle with a_rdata = 0x0000.
- A writes 0x1234 to 0x05, then B reads 0x05 the next cycle -> b_rdata = 0x1234, b_rvalid pulse exactly one cycle.
- FIXED_PRIO = 0, both ports request reads continuously for 6 cycles -> grants alternate A,B,A,B,A,B; each port sees 3 rvalid pulses.
- FIXED_PRIO = 1, same stimulus -> A granted all 6 cycles, b_gnt stays 0; B is granted the cycle after a_req drops.
- A read granted, then rst_n pulsed low mid-cycle before the posedge -> a_rvalid = 0, a_rdata = 0, FSM IDLE; the next conflict is won by A.
- With DMEM_ARB_LOCK_EN: B reads 0x20 with lock = 1, A requests continuously, B writes 0x20 with lock = 0 -> a_gnt = 0 for both B cycles, then a_gnt = 1 on the third cycle.
